// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   fetch_entry_t : one buffered fetch result {pc, instr, misalign}
//   FETCH_DEPTH   : number of entries in the fetch buffer
//   PC_STEP       : sequential fetch increment in bytes
// Helpers:
//   pc_misaligned : target is not word aligned
//   pc_align      : clear the two byte-offset bits of a target
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_DEPTH = 2;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
// Two-entry in-order FIFO holding fetched instructions for decode.
// The head entry is always slot 0, so the head output comes straight from a
// register. Push and pop of a full buffer in the same cycle are allowed.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (empties buffer, clears slots)
//   i_flush  : synchronous flush; wins over push and pop
//   i_push   : write i_din at the tail
//   i_din    : entry to write
//   i_pop    : remove the head entry
//   o_head   : head entry (slot 0)
//   o_full   : buffer holds FETCH_DEPTH entries
//   o_empty  : buffer holds no entry
//   o_count  : number of buffered entries
// -----------------------------------------------------------------------------
module fetch_buf
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_din,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  fetch_entry_t r_e0;
  fetch_entry_t r_e1;
  logic [1:0]   r_count;

  fetch_entry_t w_e0_nxt;
  fetch_entry_t w_e1_nxt;
  logic [1:0]   w_count_nxt;
  logic         w_pop_ok;
  logic         w_push_ok;
  logic         w_full;

  assign w_full    = (r_count == 2'(FETCH_DEPTH));
  // A pop of an empty buffer is ignored; a push into a full buffer is only
  // taken when the head leaves in the same cycle.
  assign w_pop_ok  = i_pop && (r_count != 2'd0);
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  // Next-state for slots and occupancy.
  always_comb begin
    w_e0_nxt    = r_e0;
    w_e1_nxt    = r_e1;
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10: begin
          if (r_count == 2'd0) begin
            w_e0_nxt = i_din;
          end else begin
            w_e1_nxt = i_din;
          end
          w_count_nxt = r_count + 2'd1;
        end
        2'b01: begin
          w_e0_nxt    = r_e1;
          w_count_nxt = r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (r_count == 2'd1) begin
            w_e0_nxt = i_din;
          end else begin
            w_e0_nxt = r_e1;
            w_e1_nxt = i_din;
          end
        end
        default: begin
          w_count_nxt = r_count;
        end
      endcase
    end
  end

  // Slot and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0    <= '0;
      r_e1    <= '0;
      r_count <= 2'd0;
    end else begin
      r_e0    <= w_e0_nxt;
      r_e1    <= w_e1_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign o_head  = r_e0;
  assign o_full  = w_full;
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage: issues sequential word fetches to a memory with a
// one-cycle read latency, buffers the returned words in a 2-entry FIFO and
// presents them to decode with a valid/ready handshake. A redirect flushes
// everything and restarts fetching at the target.
//
// Build option:
//   FETCH_MISALIGN_CHK_EN defined   : a redirect to a non-word-aligned target
//                                     issues no fetch; a single fault entry
//                                     {target, 0} is presented with
//                                     if_misalign=1 and fetch then halts until
//                                     the next redirect.
//   FETCH_MISALIGN_CHK_EN undefined : the target is forced to word alignment
//                                     and if_misalign is tied low.
//
// Parameter:
//   RESET_PC       : first fetch address after reset
// Ports:
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   imem_pc        : fetch address, sampled by memory each rising edge
//   imem_instr     : memory data for the address sampled one edge earlier
//   redirect_valid : redirect request
//   redirect_pc    : redirect target
//   if_valid       : entry available to decode
//   if_ready       : decode accepts the entry this cycle
//   if_pc          : address of the presented entry
//   if_instr       : instruction word of the presented entry
//   if_misalign    : presented entry is a misaligned-target fault
// -----------------------------------------------------------------------------
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  // Fetch address register; also the next address to issue.
  logic [31:0]  r_pc;
  // A fetch was issued last cycle; its data is on imem_instr now.
  logic         r_inflight;
  logic [31:0]  r_inflight_pc;
  // A misaligned redirect was taken last cycle; push its fault entry now.
  logic         r_fault_pend;
  // Fetching stopped after a misaligned redirect.
  logic         r_halt;

  logic [31:0]  w_redirect_tgt;
  logic         w_redirect_bad;
  logic         w_pop;
  logic         w_issue;
  logic [2:0]   w_occ;
  logic         w_push;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_redirect_tgt = redirect_pc;
  assign w_redirect_bad = pc_misaligned(redirect_pc);
  assign if_misalign    = w_head.misalign;
`else
  logic w_unused_misalign;
  assign w_redirect_tgt    = pc_align(redirect_pc);
  assign w_redirect_bad    = 1'b0;
  assign if_misalign       = 1'b0;
  assign w_unused_misalign = w_head.misalign;
`endif

  // During a redirect the handshake still completes for decode; the flush
  // discards the buffer anyway, so the pop has no further effect.
  assign w_pop = if_valid && if_ready;

  // Issue decision: occupancy counts buffered entries plus the word arriving
  // from memory this cycle, minus the entry decode takes this cycle.
  always_comb begin
    w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    if (redirect_valid || r_halt || r_fault_pend) begin
      w_issue = 1'b0;
    end else if (w_occ < 3'(FETCH_DEPTH)) begin
      w_issue = 1'b1;
    end else begin
      w_issue = 1'b0;
    end
  end

  // Buffer write: either the fault entry of a misaligned redirect or the
  // memory word for last cycle's issue; a redirect this cycle suppresses both.
  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    if (redirect_valid) begin
      w_push = 1'b0;
    end else if (r_fault_pend) begin
      w_push                = 1'b1;
      w_push_entry.pc       = r_pc;
      w_push_entry.instr    = 32'h0000_0000;
      w_push_entry.misalign = 1'b1;
    end else if (r_inflight && (!w_full || w_pop)) begin
      w_push                = 1'b1;
      w_push_entry.pc       = r_inflight_pc;
      w_push_entry.instr    = imem_instr;
      w_push_entry.misalign = 1'b0;
    end else begin
      w_push = 1'b0;
    end
  end

  // Fetch address, in-flight tracking and misalign fault state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0000_0000;
      r_fault_pend  <= 1'b0;
      r_halt        <= 1'b0;
    end else if (redirect_valid) begin
      // The word for the address on imem_pc this cycle is never pushed.
      r_pc         <= w_redirect_tgt;
      r_inflight   <= 1'b0;
      r_fault_pend <= w_redirect_bad;
      r_halt       <= w_redirect_bad;
    end else begin
      r_fault_pend <= 1'b0;
      r_inflight   <= w_issue;
      if (w_issue) begin
        r_pc          <= r_pc + PC_STEP;
        r_inflight_pc <= r_pc;
      end else begin
        r_pc          <= r_pc;
        r_inflight_pc <= r_inflight_pc;
      end
    end
  end

  fetch_buf u_fetch_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign imem_pc  = r_pc;
  assign if_valid = !w_empty;
  assign if_pc    = w_head.pc;
  assign if_instr = w_head.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed timing checks plus randomized ready/redirect traffic. A stream
// model (next expected address, restart on redirect or reset) feeds an
// expected-entry queue; a negedge monitor pops it on every accepted transfer.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int n_checks = 0;
  int n_errors = 0;
  int n_xfers  = 0;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Instruction memory with one-cycle read latency.
  always @(posedge clk) imem_instr <= mem_word(imem_pc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference stream model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_next;
  bit          m_halt;

  function automatic void model_restart(input logic [31:0] tgt);
    exp_t e;
    exp_q.delete();
    m_halt = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    if (tgt[1:0] != 2'b00) begin
      e.pc = tgt; e.instr = 32'h0; e.mis = 1'b1;
      exp_q.push_back(e);
      m_halt = 1'b1;
    end else begin
      m_next = tgt;
    end
`else
    m_next = {tgt[31:2], 2'b00};
`endif
  endfunction

  function automatic void model_top_up();
    exp_t e;
    while (!m_halt && exp_q.size() < 4) begin
      e.pc = m_next; e.instr = mem_word(m_next); e.mis = 1'b0;
      exp_q.push_back(e);
      m_next = m_next + 32'd4;
    end
  endfunction

  // Monitor: compare accepted transfers against the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      model_restart(RST_PC);
    end else begin
      if (if_valid && if_ready) begin
        n_xfers++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got transfer pc %h expected none", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", if_pc, e.pc);
          check("sb_instr", if_instr, e.instr);
          check_b("sb_misalign", if_misalign, e.mis);
        end
      end
      if (redirect_valid) model_restart(redirect_pc);
    end
    model_top_up();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom();
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    if ($urandom_range(0, 7) == 0) t[31:4] = 28'hFFF_FFFF;
    return t;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check_b("rst_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check_b("rst_misalign", if_misalign, 1'b0);
    check("rst_imem_pc", imem_pc, RST_PC);

    // Release: cycle 0 issues RESET_PC, presented in cycle 2
    tick(); reset_n = 1'b1;
    sample(); check("c0_imem_pc", imem_pc, 32'h100);
    tick(); sample(); check("c1_imem_pc", imem_pc, 32'h104); check_b("c1_valid", if_valid, 1'b0);
    tick(); sample(); check_b("c2_valid", if_valid, 1'b1); check("c2_pc", if_pc, 32'h100);

    // Backpressure for 5 cycles at 104
    for (int i = 0; i < 5; i++) begin
      tick(); if_ready = 1'b0;
      sample();
      check_b("bp_valid", if_valid, 1'b1);
      check("bp_pc", if_pc, 32'h104);
      check("bp_instr", if_instr, mem_word(32'h104));
      check("bp_imem_pc", imem_pc, 32'h10C);
    end
    tick(); if_ready = 1'b1; sample(); check("bp_rel0", if_pc, 32'h104);
    tick(); sample(); check("bp_rel1", if_pc, 32'h108);
    tick(); sample(); check("bp_rel2", if_pc, 32'h10C);

    // Fill the buffer, then redirect to 200 with ready high
    tick(); if_ready = 1'b0; sample();
    tick(); sample();
    tick(); sample();
    tick(); if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    sample(); check_b("rd_n_valid", if_valid, 1'b1);
    tick(); redirect_valid = 1'b0;
    sample(); check_b("rd_n1_valid", if_valid, 1'b0); check("rd_n1_imem_pc", imem_pc, 32'h200);
    tick(); sample(); check_b("rd_n2_valid", if_valid, 1'b0);
    tick(); sample(); check_b("rd_n3_valid", if_valid, 1'b1); check("rd_n3_pc", if_pc, 32'h200);

    // Back-to-back redirects 300 then 400
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h300; sample();
    tick(); redirect_pc = 32'h400;
    sample(); check_b("dr_n1_valid", if_valid, 1'b0); check("dr_n1_imem_pc", imem_pc, 32'h300);
    tick(); redirect_valid = 1'b0;
    sample(); check_b("dr_n2_valid", if_valid, 1'b0); check("dr_n2_imem_pc", imem_pc, 32'h400);
    tick(); sample(); check_b("dr_n3_valid", if_valid, 1'b0);
    tick(); sample(); check_b("dr_n4_valid", if_valid, 1'b1); check("dr_n4_pc", if_pc, 32'h400);

    // Misaligned redirect to 202
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h202; sample();
    tick(); redirect_valid = 1'b0; sample(); check_b("ma_n1_valid", if_valid, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
    tick(); sample();
    check_b("ma_n2_valid", if_valid, 1'b1);
    check_b("ma_n2_mis", if_misalign, 1'b1);
    check("ma_n2_pc", if_pc, 32'h202);
    check("ma_n2_instr", if_instr, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(); sample();
      check_b("ma_halt_valid", if_valid, 1'b0);
      check("ma_halt_imem_pc", imem_pc, 32'h202);
    end
`else
    tick(); sample(); check_b("ma_n2_valid", if_valid, 1'b0);
    tick(); sample();
    check_b("ma_n3_valid", if_valid, 1'b1);
    check("ma_n3_pc", if_pc, 32'h200);
    check_b("ma_n3_mis", if_misalign, 1'b0);
`endif

    // Wrap at the top of the address space
    tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; sample();
    tick(); redirect_valid = 1'b0; sample();
    tick(); sample();
    tick(); sample(); check("wr_n3_pc", if_pc, 32'hFFFF_FFFC); check_b("wr_n3_valid", if_valid, 1'b1);
    tick(); sample(); check("wr_n4_pc", if_pc, 32'h0);
    tick(); sample(); check("wr_n5_pc", if_pc, 32'h4);

    // Mid-stream reset: outputs clear immediately
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_b("mr_valid", if_valid, 1'b0);
    check("mr_if_pc", if_pc, 32'h0);
    check("mr_if_instr", if_instr, 32'h0);
    check("mr_imem_pc", imem_pc, RST_PC);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    sample(); check("mr_c0_imem_pc", imem_pc, 32'h100);
    tick(); sample(); check_b("mr_c1_valid", if_valid, 1'b0);
    tick(); sample(); check_b("mr_c2_valid", if_valid, 1'b1); check("mr_c2_pc", if_pc, 32'h100);

    // Randomized ready and redirect traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = rand_target();
    end

    // Final redirect must restart the stream on time
    tick(); if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; sample();
    tick(); redirect_valid = 1'b0; sample();
    tick(); sample();
    tick(); sample(); check_b("fin_valid", if_valid, 1'b1); check("fin_pc", if_pc, 32'h500);
    repeat (4) begin tick(); sample(); end
    check_b("xfer_progress", (n_xfers > 100), 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
